mc_controller: RTL and testbench

Multicycle control FSM for the RISC-V core. It sequences a shared datapath: one memory for instructions and data, one ALU, and the IR/OldPC/ALUOut/Data holding registers, across several cycles per instruction. Each cycle it drives the mux selects and write enables. ALU function selection reuses the existing ALU decode.

---
 rtl/mc_pkg.sv | 159 +++++++++++++++
 rtl/alu_decoder.sv | 33 +++
 rtl/mc_controller.sv | 99 +++++++++
 tb/tb_mc_controller.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle RISC-V control FSM.
// Consumed by mc_controller and alu_decoder via import mc_pkg::*.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMREAD = 4'd3,
        MEMWB   = 4'd4,
        MEMWRITE= 4'd5,
        EXECR   = 4'd6,
        EXECI   = 4'd7,
        ALUWB   = 4'd8,
        BRANCH  = 4'd9,
        JAL     = 4'd10,
        JALRADR = 4'd11,
        LUI     = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    typedef struct packed {
        logic       pcupdate;
        logic       branch;
        logic       adrsrc;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic [1:0] resultsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
    } ctrl_t;

    // Moore output word for each state; anything not set stays 0.
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.irwrite   = 1'b1;
                c.pcupdate  = 1'b1;
                c.alusrca   = SRCA_PC;
                c.alusrcb   = SRCB_FOUR;
                c.resultsrc = RES_ALURESULT;
            end
            DECODE: begin
                c.alusrca = SRCA_OLDPC;
                c.alusrcb = SRCB_IMM;
            end
            MEMADR, JALRADR: begin
                c.alusrca = SRCA_RS1;
                c.alusrcb = SRCB_IMM;
            end
            MEMREAD: c.adrsrc = 1'b1;
            MEMWB: begin
                c.resultsrc = RES_DATA;
                c.regwrite  = 1'b1;
            end
            MEMWRITE: begin
                c.adrsrc   = 1'b1;
                c.memwrite = 1'b1;
            end
            EXECR: begin
                c.alusrca = SRCA_RS1;
                c.alusrcb = SRCB_RS2;
                c.aluop   = ALUOP_FUNCT;
            end
            EXECI: begin
                c.alusrca = SRCA_RS1;
                c.alusrcb = SRCB_IMM;
                c.aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                c.resultsrc = RES_ALUOUT;
                c.regwrite  = 1'b1;
            end
            BRANCH: begin
                c.alusrca   = SRCA_RS1;
                c.alusrcb   = SRCB_RS2;
                c.aluop     = ALUOP_SUB;
                c.resultsrc = RES_ALUOUT;
                c.branch    = 1'b1;
            end
            JAL: begin
                c.alusrca   = SRCA_OLDPC;
                c.alusrcb   = SRCB_FOUR;
                c.resultsrc = RES_ALUOUT;
                c.pcupdate  = 1'b1;
            end
            LUI: begin
                c.alusrca = SRCA_ZERO;
                c.alusrcb = SRCB_IMM;
            end
            default: ;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] imm_src(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC: return IMM_U;
            OP_JAL:           return IMM_J;
            OP_BRANCH:        return IMM_B;
            OP_STORE:         return IMM_S;
            default:          return IMM_I;
        endcase
    endfunction

    function automatic logic op_supported(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU function decode shared with the single-cycle core: ALUOp selects
// add, subtract, or the operation named by funct3/funct7.
module alu_decoder
    import mc_pkg::*;
(
    input  logic       opb5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic [1:0] aluop,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            default: begin
                case (funct3)
                    3'b000:  alucontrol = (opb5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alucontrol = ALU_SLL;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b011:  alucontrol = ALU_SLT;
                    3'b100:  alucontrol = ALU_XOR;
                    3'b101:  alucontrol = ALU_SRL;
                    3'b110:  alucontrol = ALU_OR;
                    default: alucontrol = ALU_AND;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control FSM sequencing the shared datapath one state per cycle.
// Define MC_MEM_READY_EN to add mem_ready stalls in FETCH/MEMREAD/MEMWRITE.
module mc_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
`ifdef MC_MEM_READY_EN
    input  logic       mem_ready,
`endif
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal
);

    state_t state, state_n;
    ctrl_t  ctrl;
    logic   mem_go;
    logic   taken;

`ifdef MC_MEM_READY_EN
    assign mem_go = mem_ready;
`else
    assign mem_go = 1'b1;
`endif

    always_comb begin
        state_n = state;
        case (state)
            FETCH:    if (mem_go) state_n = DECODE;
            DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_n = MEMADR;
                    OP_RTYPE:          state_n = EXECR;
                    OP_ITYPE:          state_n = EXECI;
                    OP_BRANCH:         state_n = BRANCH;
                    OP_JAL:            state_n = JAL;
                    OP_JALR:           state_n = JALRADR;
                    OP_LUI:            state_n = LUI;
                    OP_AUIPC:          state_n = ALUWB;
                    default:           state_n = FETCH;
                endcase
            end
            MEMADR:   state_n = op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  if (mem_go) state_n = MEMWB;
            MEMWRITE: if (mem_go) state_n = FETCH;
            EXECR, EXECI, JAL, LUI: state_n = ALUWB;
            JALRADR:  state_n = JAL;
            default:  state_n = FETCH;
        endcase
    end

    // The output word tracks the state it will describe, so ctrl always equals state_ctrl(state).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= FETCH;
            ctrl  <= state_ctrl(FETCH);
        end else begin
            state <= state_n;
            ctrl  <= state_ctrl(state_n);
        end
    end

    assign taken = (funct3 == 3'b000) ? Zero :
                   (funct3 == 3'b001) ? ~Zero : 1'b0;

    // irwrite is only set in FETCH, so it doubles as the "waiting on fetch" marker for PC gating.
    assign PCWrite   = reset_n & ((ctrl.pcupdate & (mem_go | ~ctrl.irwrite)) | (ctrl.branch & taken));
    assign IRWrite   = reset_n & ctrl.irwrite & mem_go;
    assign RegWrite  = reset_n & ctrl.regwrite;
    assign MemWrite  = reset_n & ctrl.memwrite;
    assign illegal   = reset_n & (state == DECODE) & ~op_supported(op);
    assign AdrSrc    = ctrl.adrsrc;
    assign ResultSrc = ctrl.resultsrc;
    assign ALUSrcA   = ctrl.alusrca;
    assign ALUSrcB   = ctrl.alusrcb;
    assign ImmSrc    = imm_src(op);

    alu_decoder u_alu_decoder (
        .opb5       (op[5]),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .aluop      (ctrl.aluop),
        .alucontrol (ALUControl)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed instruction scenarios plus
// a randomized instruction stream checked against a per-instruction cycle model.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] op = 7'h7F;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0;
`ifdef MC_MEM_READY_EN
    logic       mem_ready = 1'b1;
`endif
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc, ALUControl;

    int checks = 0;
    int errors = 0;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BR = 4;
    localparam int K_JAL = 5, K_JALR = 6, K_LUI = 7, K_AUIPC = 8, K_ILL = 9;

    typedef struct packed {
        bit       pcw;
        bit       irw;
        bit       rw;
        bit       mw;
        bit       adr;
        bit [1:0] rs;
        bit [1:0] sa;
        bit [1:0] sb;
        bit       ill;
        bit       br;
        bit [1:0] alu;
    } step_t;

    step_t seq[$];

    mc_controller dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
`ifdef MC_MEM_READY_EN
        .mem_ready  (mem_ready),
`endif
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic bit [6:0] op_of(input int k);
        case (k)
            K_LW:    return 7'b0000011;
            K_SW:    return 7'b0100011;
            K_R:     return 7'b0110011;
            K_I:     return 7'b0010011;
            K_BR:    return 7'b1100011;
            K_JAL:   return 7'b1101111;
            K_JALR:  return 7'b1100111;
            K_LUI:   return 7'b0110111;
            K_AUIPC: return 7'b0010111;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic step_t mk(input bit pcw, input bit irw, input bit rw, input bit mw,
                                 input bit adr, input bit [1:0] rs, input bit [1:0] sa,
                                 input bit [1:0] sb, input bit ill, input bit br,
                                 input bit [1:0] alu);
        step_t s;
        s = {pcw, irw, rw, mw, adr, rs, sa, sb, ill, br, alu};
        return s;
    endfunction

    // Expected per-cycle behaviour of one instruction, cycle by cycle.
    task automatic model_instr(input int k);
        step_t memadr, aluwb, jal;
        memadr = mk(0,0,0,0,0,2'b00,2'b10,2'b01,0,0,2'd0);
        aluwb  = mk(0,0,1,0,0,2'b00,2'b00,2'b00,0,0,2'd0);
        jal    = mk(1,0,0,0,0,2'b00,2'b01,2'b10,0,0,2'd0);
        seq.delete();
        seq.push_back(mk(1,1,0,0,0,2'b10,2'b00,2'b10,0,0,2'd0));
        seq.push_back(mk(0,0,0,0,0,2'b00,2'b01,2'b01,(k == K_ILL),0,2'd0));
        case (k)
            K_LW: begin
                seq.push_back(memadr);
                seq.push_back(mk(0,0,0,0,1,2'b00,2'b00,2'b00,0,0,2'd0));
                seq.push_back(mk(0,0,1,0,0,2'b01,2'b00,2'b00,0,0,2'd0));
            end
            K_SW: begin
                seq.push_back(memadr);
                seq.push_back(mk(0,0,0,1,1,2'b00,2'b00,2'b00,0,0,2'd0));
            end
            K_R: begin
                seq.push_back(mk(0,0,0,0,0,2'b00,2'b10,2'b00,0,0,2'd2));
                seq.push_back(aluwb);
            end
            K_I: begin
                seq.push_back(mk(0,0,0,0,0,2'b00,2'b10,2'b01,0,0,2'd2));
                seq.push_back(aluwb);
            end
            K_BR:    seq.push_back(mk(0,0,0,0,0,2'b00,2'b10,2'b00,0,1,2'd1));
            K_JAL: begin
                seq.push_back(jal);
                seq.push_back(aluwb);
            end
            K_JALR: begin
                seq.push_back(mk(0,0,0,0,0,2'b00,2'b10,2'b01,0,0,2'd0));
                seq.push_back(jal);
                seq.push_back(aluwb);
            end
            K_LUI: begin
                seq.push_back(mk(0,0,0,0,0,2'b00,2'b11,2'b01,0,0,2'd0));
                seq.push_back(aluwb);
            end
            K_AUIPC: seq.push_back(aluwb);
            default: ;
        endcase
    endtask

    function automatic bit [2:0] exp_alu(input bit [1:0] alu, input bit op5,
                                         input bit [2:0] f3, input bit f7);
        bit [2:0] ftab [8];
        ftab = '{3'b000, 3'b110, 3'b101, 3'b101, 3'b100, 3'b111, 3'b011, 3'b010};
        if (alu == 2'd0) return 3'b000;
        if (alu == 2'd1) return 3'b001;
        if (f3 == 3'b000 && op5 && f7) return 3'b001;
        return ftab[f3];
    endfunction

    function automatic bit [2:0] exp_imm(input int k);
        case (k)
            K_LUI, K_AUIPC: return 3'b100;
            K_JAL:          return 3'b011;
            K_BR:           return 3'b010;
            K_SW:           return 3'b001;
            default:        return 3'b000;
        endcase
    endfunction

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({PCWrite, IRWrite, RegWrite, MemWrite, illegal} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_enables: got %b expected 00000",
                     {PCWrite, IRWrite, RegWrite, MemWrite, illegal});
        end
        checks++;
        if ({AdrSrc, ResultSrc, ALUSrcA, ALUSrcB} !== 7'b0_10_00_10) begin
            errors++;
            $display("[TB] FAIL reset_selects: got %b expected 0100010",
                     {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB});
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        checks++;
        if ({IRWrite, PCWrite} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL release_fetch: got %b expected 11", {IRWrite, PCWrite});
        end
    endtask

    task automatic test_lw();
        op = 7'b0000011;
        funct3 = 3'b010;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            checks++;
            if ((RegWrite && ResultSrc == 2'b01) !== (c == 5)) begin
                errors++;
                $display("[TB] FAIL lw_writeback c%0d: got %b expected %b",
                         c, (RegWrite && ResultSrc == 2'b01), (c == 5));
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (IRWrite !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lw_next_fetch: got %b expected 1", IRWrite);
        end
    endtask

    task automatic test_sw();
        op = 7'b0100011;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++;
            if (MemWrite !== (c == 4) || (c == 4 && AdrSrc !== 1'b1)) begin
                errors++;
                $display("[TB] FAIL sw_memwrite c%0d: got mw=%b adr=%b expected mw=%b adr=1",
                         c, MemWrite, AdrSrc, (c == 4));
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (IRWrite !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sw_next_fetch: got %b expected 1", IRWrite);
        end
    endtask

    task automatic test_branch();
        bit [2:0] f3s [4];
        bit       zs  [4];
        bit       pcw [4];
        f3s = '{3'b000, 3'b000, 3'b001, 3'b100};
        zs  = '{1'b1, 1'b0, 1'b0, 1'b1};
        pcw = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            op = 7'b1100011;
            funct3 = f3s[i];
            Zero = zs[i];
            for (int c = 1; c <= 3; c++) begin
                @(negedge clk);
                if (c == 3) begin
                    checks++;
                    if (PCWrite !== pcw[i] || ALUControl !== 3'b001) begin
                        errors++;
                        $display("[TB] FAIL branch_pcwrite case%0d: got pcw=%b alu=%b expected pcw=%b alu=001",
                                 i, PCWrite, ALUControl, pcw[i]);
                    end
                end
                @(posedge clk);
                #1;
            end
            checks++;
            if (IRWrite !== 1'b1) begin
                errors++;
                $display("[TB] FAIL branch_next_fetch case%0d: got %b expected 1", i, IRWrite);
            end
        end
        Zero = 1'b0;
    endtask

    task automatic test_jalr();
        op = 7'b1100111;
        funct3 = 3'b000;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            checks++;
            case (c)
                3: if (PCWrite !== 1'b0 || ALUSrcA !== 2'b10) begin
                    errors++;
                    $display("[TB] FAIL jalr_adr: got pcw=%b srca=%b expected pcw=0 srca=10", PCWrite, ALUSrcA);
                end
                4: if (PCWrite !== 1'b1 || RegWrite !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL jalr_jal: got pcw=%b rw=%b expected pcw=1 rw=0", PCWrite, RegWrite);
                end
                5: if (RegWrite !== 1'b1 || ResultSrc !== 2'b00) begin
                    errors++;
                    $display("[TB] FAIL jalr_wb: got rw=%b rs=%b expected rw=1 rs=00", RegWrite, ResultSrc);
                end
                default: if (RegWrite !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL jalr_early_rw c%0d: got %b expected 0", c, RegWrite);
                end
            endcase
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_illegal();
        op = 7'h7F;
        @(negedge clk);
        checks++;
        if (illegal !== 1'b0) begin
            errors++;
            $display("[TB] FAIL illegal_in_fetch: got %b expected 0", illegal);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({illegal, PCWrite, RegWrite, MemWrite, IRWrite} !== 5'b10000) begin
            errors++;
            $display("[TB] FAIL illegal_decode: got %b expected 10000",
                     {illegal, PCWrite, RegWrite, MemWrite, IRWrite});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({IRWrite, illegal} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL illegal_return: got %b expected 10", {IRWrite, illegal});
        end
    endtask

    task automatic test_reset_midinstr();
        op = 7'b0000011;
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if ({ALUSrcA, ALUSrcB} !== 4'b1001) begin
            errors++;
            $display("[TB] FAIL memadr_before_reset: got %b expected 1001", {ALUSrcA, ALUSrcB});
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({PCWrite, IRWrite, RegWrite, MemWrite, illegal, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB}
                !== 12'b00000_0_10_00_10) begin
            errors++;
            $display("[TB] FAIL async_reset: got %b expected 000000100010",
                     {PCWrite, IRWrite, RegWrite, MemWrite, illegal, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB});
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({IRWrite, PCWrite, ALUSrcA} !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL fetch_after_reset: got %b expected 1100", {IRWrite, PCWrite, ALUSrcA});
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({IRWrite, ALUSrcA} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL decode_after_reset: got %b expected 001", {IRWrite, ALUSrcA});
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

`ifdef MC_MEM_READY_EN
    task automatic test_mem_ready();
        op = 7'b0110011;
        mem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({IRWrite, PCWrite} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL fetch_stall c%0d: got %b expected 00", c, {IRWrite, PCWrite});
            end
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({IRWrite, PCWrite} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL fetch_ready: got %b expected 11", {IRWrite, PCWrite});
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({IRWrite, PCWrite, ALUSrcA} !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL decode_after_stall: got %b expected 0001", {IRWrite, PCWrite, ALUSrcA});
        end
        repeat (3) @(posedge clk);
        #1;
    endtask
`endif

    task automatic test_random();
        bit [6:0] ill_ops [4];
        ill_ops = '{7'h7F, 7'h00, 7'h73, 7'h0F};
        for (int n = 0; n < 60; n++) begin
            int k;
            k = $urandom_range(0, 9);
            op = (k == K_ILL) ? ill_ops[$urandom_range(0, 3)] : op_of(k);
            funct3 = 3'($urandom_range(0, 7));
            funct7b5 = 1'($urandom_range(0, 1));
            model_instr(k);
            foreach (seq[i]) begin
                logic [17:0] got, want;
                bit taken;
                Zero = 1'($urandom_range(0, 1));
                @(negedge clk);
                taken = (funct3 == 3'b000 && Zero) || (funct3 == 3'b001 && !Zero);
                want = {seq[i].pcw | (seq[i].br & taken), seq[i].irw, seq[i].rw, seq[i].mw,
                        seq[i].adr, seq[i].rs, seq[i].sa, seq[i].sb, seq[i].ill,
                        exp_imm(k), exp_alu(seq[i].alu, op[5], funct3, funct7b5)};
                got  = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc,
                        ALUSrcA, ALUSrcB, illegal, ImmSrc, ALUControl};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("[TB] FAIL random n%0d kind%0d cycle%0d: got %b expected %b",
                             n, k, i + 1, got, want);
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_branch();
        test_jalr();
        test_illegal();
        test_reset_midinstr();
`ifdef MC_MEM_READY_EN
        test_mem_ready();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
